regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the register file's single write port.
- Arbitrates between three requesters:
  - memory-load writeback (ld), single-cycle;
  - ALU writeback (wb), single-cycle;
  - immediate loader (imm), which builds a 16-bit constant as four sequential nibble writes.
- Drives the register file's write, writeReg, writeData and quarter inputs from registered outputs.
- Sits between the pipeline writeback stage and the register file.

Parameters:
- DATA_W, 16, register/data width.
- RIDX_W, 4, register index width.
- NREG, 8, number of implemented registers; indices >= NREG are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ld_valid  in  1  load writeback request.
- ld_reg  in  RIDX_W  load destination.
- ld_data  in  DATA_W  load data.
- ld_ready  out  1  load accepted this cycle.
- wb_valid  in  1  ALU writeback request.
- wb_reg  in  RIDX_W  ALU destination.
- wb_data  in  DATA_W  ALU result.
- wb_ready  out  1  ALU request accepted this cycle.
- imm_valid  in  1  immediate-load request.
- imm_reg  in  RIDX_W  immediate destination.
- imm_data  in  DATA_W  immediate value.
- imm_ready  out  1  immediate accepted this cycle.
- imm_done  out  1  pulse in the cycle the final nibble write is presented.
- rf_write  out  1  register-file write enable.
- rf_reg  out  RIDX_W  register-file write index.
- rf_data  out  DATA_W  register-file write data.
- rf_quarter  out  3  0..3 = nibble select; 4 = full-word write.
- busy_reg  out  RIDX_W  destination of an in-progress immediate burst.
- busy  out  1  immediate burst in progress.
- illegal_wr  out  1  pulse: accepted request targeted an index >= NREG.

Behaviour:
- Reset values (asynchronous, immediate on rst=1): all outputs 0, FSM = IDLE.
- Reset mid-burst aborts the burst; no further nibbles are written.
- ready signals are combinational from FSM state and the valids.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - Requesters hold valid and payload stable until ready.
- Arbitration in IDLE, fixed priority ld > wb > imm; exactly one ready high per cycle, or none.
- ld/wb accept:
  - Next cycle: rf_write=1, rf_reg and rf_data taken from the request, rf_quarter=4.
  - Latency 1 cycle.
  - Back-to-back single-cycle accepts are allowed every cycle.
- imm accept:
  - Latch imm_reg and imm_data, then go to NIB0.
  - busy=1 and busy_reg=imm_reg from the next cycle until the cycle after NIB3.
- Burst states NIB0, NIB1, NIB2, NIB3, one cycle each:
  - rf_write=1, rf_reg=latched reg, rf_quarter=k.
  - rf_data[3:0] = latched data[4k+3:4k]; upper bits 0.
- Transitions: NIB0 -> NIB1 -> NIB2 -> NIB3 -> IDLE.
  - imm_done=1 during the NIB3 output cycle.
  - In NIB3, the arbiter may accept a new request (any type); its write appears in the following cycle. No bubble.
- During NIB0..NIB2 all readies are 0; the burst is atomic.
- Illegal index:
  - Request is accepted (ready=1).
  - Next cycle: rf_write stays 0, illegal_wr=1 for one cycle.
  - For imm, the whole burst is suppressed and imm_done is not pulsed.
- Idle cycles: rf_write=0; rf_reg, rf_data and rf_quarter hold their last values.
- Simultaneous ld and wb valid: ld wins, wb waits. Without the optional feature, wb starvation is permitted.

Optional Feature:
- Macro: REGFILE_WR_RR_EN.
- Defined: ld and wb arbitrate round-robin. A 1-bit last-grant flop (reset = wb granted) gives priority to whichever of ld/wb was not granted most recently. imm remains lowest priority.
- Undefined: fixed ld > wb > imm.

Decomposition:
- Shared package (regfile_pkg):
  - DATA_W, RIDX_W, NREG constants;
  - QTR_FULL = 3'd4;
  - the FSM state enum (IDLE, NIB0..NIB3).
- Sub-module: regfile_wr_prio, a combinational 3-way grant generator containing the RR_EN last-grant flop. The top level holds the FSM and output registers.

Test Plan:
- ld_valid=1, ld_reg=2, ld_data=16'hBEEF -> ld_ready same cycle; next cycle rf_write=1, rf_reg=2, rf_data=16'hBEEF, rf_quarter=4.
- ld and wb valid together (wb_reg=3, wb_data=16'h0001) -> ld granted first, wb_ready one cycle later; two consecutive full writes. With REGFILE_WR_RR_EN and repeated contention, grants alternate ld/wb.
- imm_valid, imm_reg=4, imm_data=16'h1234 -> four writes with quarter 0..3 and data nibbles 4, 3, 2, 1; busy=1, busy_reg=4; imm_done on the fourth write.
- wb_valid held during an imm burst -> wb_ready=0 through NIB0..NIB2, asserted in NIB3; wb write lands the cycle after NIB3.
- wb_reg=9 -> wb_ready=1; next cycle illegal_wr=1 and rf_write=0.
- rst asserted during NIB1 -> all outputs 0 immediately; after release, IDLE with no residual writes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, burst FSM state type and small helpers for the register-file write arbiter.
// Optional build macro REGFILE_WR_RR_EN (round-robin ld/wb) is consumed by the other files.
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int RIDX_W = 4;
    localparam int NREG   = 8;

    localparam logic [2:0] QTR_FULL = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        NIB0,
        NIB1,
        NIB2,
        NIB3
    } state_t;

    function automatic logic reg_legal(input logic [RIDX_W-1:0] idx);
        return int'(idx) < NREG;
    endfunction

    // Nibble k of a word, placed in the low four bits with the rest zeroed.
    function automatic logic [DATA_W-1:0] nibble(input logic [DATA_W-1:0] data,
                                                 input logic [1:0]        k);
        return {{(DATA_W-4){1'b0}}, data[{k, 2'b00} +: 4]};
    endfunction

endpackage

// File: rtl/regfile_wr_prio.sv
// Three-way grant generator for the write port: ld and wb first, imm lowest.
// With REGFILE_WR_RR_EN defined, ld/wb alternate via a last-grant flop; otherwise ld > wb fixed.
module regfile_wr_prio (
`ifdef REGFILE_WR_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic en,
    input  logic ld_req,
    input  logic wb_req,
    input  logic imm_req,
    output logic ld_gnt,
    output logic wb_gnt,
    output logic imm_gnt
);

    logic ld_first;

`ifdef REGFILE_WR_RR_EN
    // Reset value behaves as though wb was granted last, so ld wins the first contest.
    logic last_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ld <= 1'b0;
        end else if (ld_gnt) begin
            last_ld <= 1'b1;
        end else if (wb_gnt) begin
            last_ld <= 1'b0;
        end
    end

    assign ld_first = !last_ld;
`else
    assign ld_first = 1'b1;
`endif

    always_comb begin
        ld_gnt  = 1'b0;
        wb_gnt  = 1'b0;
        imm_gnt = 1'b0;
        if (en) begin
            if (ld_req && (ld_first || !wb_req)) begin
                ld_gnt = 1'b1;
            end else if (wb_req) begin
                wb_gnt = 1'b1;
            end else if (imm_req) begin
                imm_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: single-cycle ld/wb writebacks and 4-nibble immediate bursts.
// Build option REGFILE_WR_RR_EN selects round-robin between ld and wb (see regfile_wr_prio).
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [RIDX_W-1:0] ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              imm_valid,
    input  logic [RIDX_W-1:0] imm_reg,
    input  logic [DATA_W-1:0] imm_data,
    output logic              imm_ready,
    output logic              imm_done,
    output logic              rf_write,
    output logic [RIDX_W-1:0] rf_reg,
    output logic [DATA_W-1:0] rf_data,
    output logic [2:0]        rf_quarter,
    output logic [RIDX_W-1:0] busy_reg,
    output logic              busy,
    output logic              illegal_wr
);

    // Handshake: a request transfers in the cycle its valid and ready are both high; requesters
    // hold valid and payload stable until then. Readies are combinational from state and valids.

    state_t            state_q, state_d;
    logic [DATA_W-1:0] imm_data_q, imm_data_d;
    logic              rf_write_d, imm_done_d, busy_d, illegal_d;
    logic [RIDX_W-1:0] rf_reg_d, busy_reg_d;
    logic [DATA_W-1:0] rf_data_d;
    logic [2:0]        rf_quarter_d;

    logic              accept_en;
    logic              ld_gnt, wb_gnt, imm_gnt;
    logic [RIDX_W-1:0] single_reg;
    logic [DATA_W-1:0] single_data;

    // New requests are taken when idle or while the last nibble is on the port.
    assign accept_en = !rst && (state_q == IDLE || state_q == NIB3);

    regfile_wr_prio u_prio (
`ifdef REGFILE_WR_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .en      (accept_en),
        .ld_req  (ld_valid),
        .wb_req  (wb_valid),
        .imm_req (imm_valid),
        .ld_gnt  (ld_gnt),
        .wb_gnt  (wb_gnt),
        .imm_gnt (imm_gnt)
    );

    assign ld_ready  = ld_gnt;
    assign wb_ready  = wb_gnt;
    assign imm_ready = imm_gnt;

    assign single_reg  = ld_gnt ? ld_reg  : wb_reg;
    assign single_data = ld_gnt ? ld_data : wb_data;

    always_comb begin
        state_d      = state_q;
        imm_data_d   = imm_data_q;
        rf_write_d   = 1'b0;
        rf_reg_d     = rf_reg;
        rf_data_d    = rf_data;
        rf_quarter_d = rf_quarter;
        imm_done_d   = 1'b0;
        busy_d       = 1'b0;
        busy_reg_d   = busy_reg;
        illegal_d    = 1'b0;

        case (state_q)
            NIB0: begin
                state_d      = NIB1;
                rf_write_d   = 1'b1;
                rf_quarter_d = 3'd1;
                rf_data_d    = nibble(imm_data_q, 2'd1);
                busy_d       = 1'b1;
            end
            NIB1: begin
                state_d      = NIB2;
                rf_write_d   = 1'b1;
                rf_quarter_d = 3'd2;
                rf_data_d    = nibble(imm_data_q, 2'd2);
                busy_d       = 1'b1;
            end
            NIB2: begin
                state_d      = NIB3;
                rf_write_d   = 1'b1;
                rf_quarter_d = 3'd3;
                rf_data_d    = nibble(imm_data_q, 2'd3);
                busy_d       = 1'b1;
                imm_done_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                if (ld_gnt || wb_gnt) begin
                    if (reg_legal(single_reg)) begin
                        rf_write_d   = 1'b1;
                        rf_reg_d     = single_reg;
                        rf_data_d    = single_data;
                        rf_quarter_d = QTR_FULL;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else if (imm_gnt) begin
                    // An illegal destination drops the whole burst; the FSM stays idle.
                    if (reg_legal(imm_reg)) begin
                        state_d      = NIB0;
                        imm_data_d   = imm_data;
                        busy_reg_d   = imm_reg;
                        busy_d       = 1'b1;
                        rf_write_d   = 1'b1;
                        rf_reg_d     = imm_reg;
                        rf_quarter_d = 3'd0;
                        rf_data_d    = nibble(imm_data, 2'd0);
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            imm_data_q <= '0;
            rf_write   <= 1'b0;
            rf_reg     <= '0;
            rf_data    <= '0;
            rf_quarter <= 3'd0;
            imm_done   <= 1'b0;
            busy       <= 1'b0;
            busy_reg   <= '0;
            illegal_wr <= 1'b0;
        end else begin
            state_q    <= state_d;
            imm_data_q <= imm_data_d;
            rf_write   <= rf_write_d;
            rf_reg     <= rf_reg_d;
            rf_data    <= rf_data_d;
            rf_quarter <= rf_quarter_d;
            imm_done   <= imm_done_d;
            busy       <= busy_d;
            busy_reg   <= busy_reg_d;
            illegal_wr <= illegal_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed cases plus randomized traffic against a
// queue-based write-port model. Compile with +define+REGFILE_WR_RR_EN to cover round-robin mode.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid, wb_valid, imm_valid;
    logic [RIDX_W-1:0] ld_reg, wb_reg, imm_reg;
    logic [DATA_W-1:0] ld_data, wb_data, imm_data;
    logic              ld_ready, wb_ready, imm_ready, imm_done;
    logic              rf_write, busy, illegal_wr;
    logic [RIDX_W-1:0] rf_reg, busy_reg;
    logic [DATA_W-1:0] rf_data;
    logic [2:0]        rf_quarter;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_reg     (ld_reg),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .imm_valid  (imm_valid),
        .imm_reg    (imm_reg),
        .imm_data   (imm_data),
        .imm_ready  (imm_ready),
        .imm_done   (imm_done),
        .rf_write   (rf_write),
        .rf_reg     (rf_reg),
        .rf_data    (rf_data),
        .rf_quarter (rf_quarter),
        .busy_reg   (busy_reg),
        .busy       (busy),
        .illegal_wr (illegal_wr)
    );

    // Model: future port writes still owed by an accepted burst, plus the expected output values.
    typedef struct packed {
        logic [RIDX_W-1:0] r;
        logic [DATA_W-1:0] d;
        logic [2:0]        q;
        logic              done;
    } wr_t;

    wr_t               exp_q[$];
    logic              m_write, m_done, m_busy, m_illegal, m_last_ld;
    logic [RIDX_W-1:0] m_reg, m_busy_reg;
    logic [DATA_W-1:0] m_data;
    logic [2:0]        m_qtr;
    logic              last_g_ld, last_g_wb, last_g_imm;
    int                n_checks = 0;
    int                n_fail = 0;
    bit                checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_grants(output logic g_ld, output logic g_wb, output logic g_imm);
        g_ld  = 1'b0;
        g_wb  = 1'b0;
        g_imm = 1'b0;
        if (rst || exp_q.size() != 0) return;
        if (ld_valid && wb_valid) begin
`ifdef REGFILE_WR_RR_EN
            if (m_last_ld) g_wb = 1'b1;
            else g_ld = 1'b1;
`else
            g_ld = 1'b1;
`endif
        end else if (ld_valid) g_ld = 1'b1;
        else if (wb_valid) g_wb = 1'b1;
        else if (imm_valid) g_imm = 1'b1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_write = 0; m_done = 0; m_busy = 0; m_illegal = 0; m_last_ld = 0;
        m_reg = '0; m_busy_reg = '0; m_data = '0; m_qtr = '0;
        last_g_ld = 0; last_g_wb = 0; last_g_imm = 0;
    endtask

    task automatic apply_wr(input wr_t w);
        m_write = 1'b1;
        m_reg   = w.r;
        m_data  = w.d;
        m_qtr   = w.q;
        m_done  = w.done;
    endtask

    task automatic model_step();
        logic g_ld, g_wb, g_imm;
        wr_t w;
        exp_grants(g_ld, g_wb, g_imm);
        last_g_ld = g_ld; last_g_wb = g_wb; last_g_imm = g_imm;
        m_write = 0; m_done = 0; m_busy = 0; m_illegal = 0;
        if (exp_q.size() != 0) begin
            apply_wr(exp_q.pop_front());
            m_busy = 1'b1;
        end else if (g_ld || g_wb) begin
            m_last_ld = g_ld;
            w.r = g_ld ? ld_reg : wb_reg;
            w.d = g_ld ? ld_data : wb_data;
            w.q = 3'd4;
            w.done = 1'b0;
            if (int'(w.r) < NREG) apply_wr(w);
            else m_illegal = 1'b1;
        end else if (g_imm) begin
            if (int'(imm_reg) < NREG) begin
                m_busy_reg = imm_reg;
                for (int k = 0; k < 4; k++) begin
                    w.r = imm_reg;
                    w.d = DATA_W'((int'(imm_data) >> (4 * k)) % 16);
                    w.q = 3'(k);
                    w.done = (k == 3);
                    exp_q.push_back(w);
                end
                apply_wr(exp_q.pop_front());
                m_busy = 1'b1;
            end else begin
                m_illegal = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        logic g_ld, g_wb, g_imm;
        if (checking) begin
            exp_grants(g_ld, g_wb, g_imm);
            chk("ld_ready", 32'(ld_ready), 32'(g_ld));
            chk("wb_ready", 32'(wb_ready), 32'(g_wb));
            chk("imm_ready", 32'(imm_ready), 32'(g_imm));
            chk("rf_write", 32'(rf_write), 32'(m_write));
            chk("rf_reg", 32'(rf_reg), 32'(m_reg));
            chk("rf_data", 32'(rf_data), 32'(m_data));
            chk("rf_quarter", 32'(rf_quarter), 32'(m_qtr));
            chk("imm_done", 32'(imm_done), 32'(m_done));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("busy_reg", 32'(busy_reg), 32'(m_busy_reg));
            chk("illegal_wr", 32'(illegal_wr), 32'(m_illegal));
        end
    end

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    function automatic logic [RIDX_W-1:0] rand_reg();
        if ($urandom_range(0, 9) == 0) return RIDX_W'($urandom_range(8, 15));
        return RIDX_W'($urandom_range(0, 7));
    endfunction

    task automatic update_drivers();
        if (last_g_ld || !ld_valid) begin
            ld_valid = ($urandom_range(0, 99) < 30);
            ld_reg   = rand_reg();
            ld_data  = DATA_W'($urandom_range(0, 65535));
        end
        if (last_g_wb || !wb_valid) begin
            wb_valid = ($urandom_range(0, 99) < 30);
            wb_reg   = rand_reg();
            wb_data  = DATA_W'($urandom_range(0, 65535));
        end
        if (last_g_imm || !imm_valid) begin
            imm_valid = ($urandom_range(0, 99) < 25);
            imm_reg   = rand_reg();
            imm_data  = DATA_W'($urandom_range(0, 65535));
        end
    endtask

    logic [3:0] nib_exp [4];

    initial begin
        nib_exp = '{4'h4, 4'h3, 4'h2, 4'h1};
        rst = 1'b1;
        ld_valid = 0; wb_valid = 0; imm_valid = 0;
        ld_reg = '0; wb_reg = '0; imm_reg = '0;
        ld_data = '0; wb_data = '0; imm_data = '0;
        model_reset();
        checking = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rf_write", 32'(rf_write), 32'd0);
        chk("reset_rf_data", 32'(rf_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Single load writeback.
        step();
        ld_valid = 1; ld_reg = 4'd2; ld_data = 16'hBEEF;
        @(negedge clk);
        chk("ld_ready_same_cycle", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 0;
        @(negedge clk);
        chk("ld_rf_write", 32'(rf_write), 32'd1);
        chk("ld_rf_reg", 32'(rf_reg), 32'd2);
        chk("ld_rf_data", 32'(rf_data), 32'hBEEF);
        chk("ld_rf_quarter", 32'(rf_quarter), 32'd4);

        // ld and wb contend: ld first, wb the next cycle.
        step();
        ld_valid = 1; ld_reg = 4'd1; ld_data = 16'h00A5;
        wb_valid = 1; wb_reg = 4'd3; wb_data = 16'h0001;
        @(negedge clk);
        chk("contend_ld_ready", 32'(ld_ready), 32'd1);
        chk("contend_wb_wait", 32'(wb_ready), 32'd0);
        step();
        ld_valid = 0;
        @(negedge clk);
        chk("contend_wb_ready", 32'(wb_ready), 32'd1);
        chk("contend_first_data", 32'(rf_data), 32'h00A5);
        step();
        wb_valid = 0;
        @(negedge clk);
        chk("contend_second_reg", 32'(rf_reg), 32'd3);
        chk("contend_second_data", 32'(rf_data), 32'h0001);

`ifdef REGFILE_WR_RR_EN
        // Continuous contention alternates ld, wb, ld, wb.
        step();
        ld_valid = 1; wb_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ld_ready", 32'(ld_ready), 32'((i % 2) == 0));
            chk("rr_wb_ready", 32'(wb_ready), 32'((i % 2) == 1));
            step();
        end
        ld_valid = 0; wb_valid = 0;
`endif

        // Immediate burst with a wb waiting behind it.
        step();
        imm_valid = 1; imm_reg = 4'd4; imm_data = 16'h1234;
        @(negedge clk);
        chk("imm_ready", 32'(imm_ready), 32'd1);
        step();
        imm_valid = 0;
        wb_valid = 1; wb_reg = 4'd6; wb_data = 16'h00C3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("burst_quarter", 32'(rf_quarter), 32'(k));
            chk("burst_data", 32'(rf_data), 32'(nib_exp[k]));
            chk("burst_busy_reg", 32'(busy_reg), 32'd4);
            chk("burst_done", 32'(imm_done), 32'(k == 3));
            chk("burst_wb_ready", 32'(wb_ready), 32'(k == 3));
            step();
        end
        wb_valid = 0;
        @(negedge clk);
        chk("after_burst_wb_reg", 32'(rf_reg), 32'd6);
        chk("after_burst_wb_qtr", 32'(rf_quarter), 32'd4);
        chk("after_burst_busy", 32'(busy), 32'd0);

        // Illegal destination.
        step();
        wb_valid = 1; wb_reg = 4'd9; wb_data = 16'hFFFF;
        @(negedge clk);
        chk("illegal_wb_ready", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 0;
        @(negedge clk);
        chk("illegal_flag", 32'(illegal_wr), 32'd1);
        chk("illegal_no_write", 32'(rf_write), 32'd0);

        // Reset in the middle of a burst.
        step();
        imm_valid = 1; imm_reg = 4'd7; imm_data = 16'hABCD;
        step();
        imm_valid = 0;
        step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_rf_write", 32'(rf_write), 32'd0);
        chk("midrst_rf_data", 32'(rf_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("postrst_rf_write", 32'(rf_write), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            update_drivers();
        end
        ld_valid = 0; wb_valid = 0; imm_valid = 0;
        repeat (6) step();
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
